// File: rtl/tank_unit.sv
// rtl/tank_unit.sv - per-player tank controller: movement, aim, fire reload, hit/invuln, death/respawn
module tank_unit #(
  parameter int         NUM_KEYS       = 6,
  parameter logic [7:0] KEY_LEFT       = 8'h04,
  parameter logic [7:0] KEY_RIGHT      = 8'h07,
  parameter logic [7:0] KEY_AIM_UP     = 8'h1A,
  parameter logic [7:0] KEY_AIM_DN     = 8'h16,
  parameter logic [7:0] KEY_FIRE       = 8'h2C,
  parameter int         X_INIT         = 140,
  parameter int         X_MIN          = 4,
  parameter int         X_MAX          = 635,
  parameter int         X_STEP         = 1,
  parameter int         TANK_SIZE      = 4,
  parameter int         AIM_W          = 6,
  parameter int         AIM_INIT       = 0,
  parameter int         AIM_MAX        = 60,
  parameter int         AIM_STEP       = 3,
  parameter int         HP_W           = 4,
  parameter int         HP_MAX         = 10,
  parameter int         RELOAD_FRAMES  = 30,
  parameter int         INVULN_FRAMES  = 20,
  parameter int         RESPAWN_FRAMES = 120
) (
  input  logic                  frame_clk,
  input  logic                  Reset,
  input  logic [8*NUM_KEYS-1:0] keycodes,
  input  logic                  hit,
  input  logic [9:0]            GroundY,
  output logic [9:0]            TankX,
  output logic [9:0]            TankY,
  output logic [9:0]            TankS,
  output logic                  Direction,
  output logic [AIM_W-1:0]      Aim,
  output logic                  shoot,
  output logic [HP_W-1:0]       HP,
  output logic                  alive,
  output logic                  invuln
);

  localparam int CNT_MAX_A = (RELOAD_FRAMES > INVULN_FRAMES) ? RELOAD_FRAMES : INVULN_FRAMES;
  localparam int CNT_MAX   = (CNT_MAX_A > RESPAWN_FRAMES) ? CNT_MAX_A : RESPAWN_FRAMES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [9:0]       X_INIT_V  = 10'(X_INIT);
  localparam logic [9:0]       X_MIN_V   = 10'(X_MIN);
  localparam logic [9:0]       X_MAX_V   = 10'(X_MAX);
  localparam logic [9:0]       X_STEP_V  = 10'(X_STEP);
  localparam logic [9:0]       X_LO      = 10'(X_MIN + X_STEP);
  localparam logic [9:0]       X_HI      = 10'(X_MAX - X_STEP);
  localparam logic [9:0]       TS_V      = 10'(TANK_SIZE);
  localparam logic [AIM_W-1:0] AIM_INIT_V = AIM_W'(AIM_INIT);
  localparam logic [AIM_W-1:0] AIM_MAX_V  = AIM_W'(AIM_MAX);
  localparam logic [AIM_W-1:0] AIM_STEP_V = AIM_W'(AIM_STEP);
  localparam logic [AIM_W-1:0] AIM_HI     = AIM_W'(AIM_MAX - AIM_STEP);
  localparam logic [HP_W-1:0]  HP_MAX_V   = HP_W'(HP_MAX);
  localparam logic [CNT_W-1:0] RELOAD_LD  = CNT_W'(RELOAD_FRAMES - 1);
  localparam logic [CNT_W-1:0] INVULN_LD  = CNT_W'(INVULN_FRAMES - 1);
  localparam logic [CNT_W-1:0] RESPAWN_LD = CNT_W'(RESPAWN_FRAMES - 1);

  typedef enum logic [1:0] {S_ALIVE, S_INVULN, S_DEAD} state_t;

  state_t           state_q, state_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             dir_q, dir_d;
  logic [AIM_W-1:0] aim_q, aim_d;
  logic [HP_W-1:0]  hp_q, hp_d;
  logic             shoot_q, shoot_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             up_prev_q, dn_prev_q, fire_prev_q;

  logic k_left, k_right, k_up, k_dn, k_fire;
  logic up_edge, dn_edge, fire_edge, fatal;

  always_comb begin
    k_left  = 1'b0;
    k_right = 1'b0;
    k_up    = 1'b0;
    k_dn    = 1'b0;
    k_fire  = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (keycodes[8*i +: 8] == KEY_LEFT)   k_left  = 1'b1;
      if (keycodes[8*i +: 8] == KEY_RIGHT)  k_right = 1'b1;
      if (keycodes[8*i +: 8] == KEY_AIM_UP) k_up    = 1'b1;
      if (keycodes[8*i +: 8] == KEY_AIM_DN) k_dn    = 1'b1;
      if (keycodes[8*i +: 8] == KEY_FIRE)   k_fire  = 1'b1;
    end
  end

  assign up_edge   = k_up & ~up_prev_q;
  assign dn_edge   = k_dn & ~dn_prev_q;
  assign fire_edge = k_fire & ~fire_prev_q;
  assign fatal     = (state_q == S_ALIVE) && hit && (hp_q <= HP_W'(1));

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    dir_d    = dir_q;
    aim_d    = aim_q;
    hp_d     = hp_q;
    shoot_d  = 1'b0;
    reload_d = reload_q;
    cnt_d    = cnt_q;
    // Terrain follows in every state; clamp below at 0.
    y_d      = (GroundY < TS_V) ? 10'd0 : GroundY - TS_V;

    case (state_q)
      S_ALIVE, S_INVULN: begin
        if (k_left && !k_right) begin
          x_d   = (x_q < X_LO) ? X_MIN_V : x_q - X_STEP_V;
          dir_d = 1'b0;
        end else if (k_right && !k_left) begin
          x_d   = (x_q > X_HI) ? X_MAX_V : x_q + X_STEP_V;
          dir_d = 1'b1;
        end

        if (up_edge && !dn_edge) begin
          aim_d = (aim_q > AIM_HI) ? AIM_MAX_V : aim_q + AIM_STEP_V;
        end else if (dn_edge && !up_edge) begin
          aim_d = (aim_q < AIM_STEP_V) ? '0 : aim_q - AIM_STEP_V;
        end

        if (fire_edge && (reload_q == '0) && !fatal) begin
          shoot_d  = 1'b1;
          reload_d = RELOAD_LD;
        end else if (reload_q != '0) begin
          reload_d = reload_q - 1'b1;
        end

        if (fatal) begin
          hp_d     = hp_q - 1'b1;
          state_d  = S_DEAD;
          cnt_d    = RESPAWN_LD;
          reload_d = '0;
        end else if ((state_q == S_ALIVE) && hit) begin
          hp_d    = hp_q - 1'b1;
          state_d = S_INVULN;
          cnt_d   = INVULN_LD;
        end else if (state_q == S_INVULN) begin
          // Leave on the edge that drains the counter so the next hit counts INVULN_FRAMES later.
          if (cnt_q <= CNT_W'(1)) begin
            state_d = S_ALIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      S_DEAD: begin
        reload_d = '0;
        if (cnt_q == '0) begin
          state_d = S_ALIVE;
          x_d     = X_INIT_V;
          hp_d    = HP_MAX_V;
          dir_d   = 1'b1;
          aim_d   = AIM_INIT_V;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = S_ALIVE;
      end
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q     <= S_ALIVE;
      x_q         <= X_INIT_V;
      y_q         <= '0;
      dir_q       <= 1'b1;
      aim_q       <= AIM_INIT_V;
      hp_q        <= HP_MAX_V;
      shoot_q     <= 1'b0;
      reload_q    <= '0;
      cnt_q       <= '0;
      up_prev_q   <= 1'b0;
      dn_prev_q   <= 1'b0;
      fire_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dir_q       <= dir_d;
      aim_q       <= aim_d;
      hp_q        <= hp_d;
      shoot_q     <= shoot_d;
      reload_q    <= reload_d;
      cnt_q       <= cnt_d;
      up_prev_q   <= k_up;
      dn_prev_q   <= k_dn;
      fire_prev_q <= k_fire;
    end
  end

  assign TankX     = x_q;
  assign TankY     = y_q;
  assign TankS     = TS_V;
  assign Direction = dir_q;
  assign Aim       = aim_q;
  assign shoot     = shoot_q;
  assign HP        = hp_q;
  assign alive     = (state_q != S_DEAD);
  assign invuln    = (state_q == S_INVULN);

endmodule

// File: tb/tb_tank_unit.sv
// tb/tb_tank_unit.sv - scoreboard bench for tank_unit with directed frame vectors
module tb_tank_unit;

  localparam logic [7:0] K_N = 8'h00;
  localparam logic [7:0] K_L = 8'h04;
  localparam logic [7:0] K_R = 8'h07;
  localparam logic [7:0] K_U = 8'h1A;
  localparam logic [7:0] K_D = 8'h16;
  localparam logic [7:0] K_F = 8'h2C;

  localparam int M_X = 1, M_Y = 2, M_D = 4, M_A = 8, M_S = 16, M_H = 32, M_AL = 64, M_IV = 128;
  localparam int M_ALL = 255;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic [47:0] keycodes;
  logic        hit;
  logic [9:0]  GroundY;
  logic [9:0]  TankX, TankY, TankS;
  logic        Direction;
  logic [5:0]  Aim;
  logic        shoot;
  logic [3:0]  HP;
  logic        alive, invuln;

  tank_unit dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycodes  (keycodes),
    .hit       (hit),
    .GroundY   (GroundY),
    .TankX     (TankX),
    .TankY     (TankY),
    .TankS     (TankS),
    .Direction (Direction),
    .Aim       (Aim),
    .shoot     (shoot),
    .HP        (HP),
    .alive     (alive),
    .invuln    (invuln)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    string tag;
    int    m;
    int    x, y, dir, aim, sh, hp, al, inv;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   gnd      = 100;

  function automatic exp_t mk(string tag, int m, int x, int y, int dir, int aim,
                              int sh, int hp, int al, int inv);
    exp_t e;
    e.tag = tag; e.m = m; e.x = x; e.y = y; e.dir = dir; e.aim = aim;
    e.sh = sh; e.hp = hp; e.al = al; e.inv = inv;
    return e;
  endfunction

  function automatic logic [47:0] kc(logic [7:0] a, logic [7:0] b, logic [7:0] c);
    return {K_N, c, K_N, b, K_N, a};
  endfunction

  task automatic chk(input string tag, input string f, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s %s got=%0d expected=%0d", tag, f, got, want);
    end
  endtask

  task automatic frame(input logic [47:0] k, input logic h, input logic r, input exp_t e);
    @(negedge frame_clk);
    keycodes = k;
    hit      = h;
    Reset    = r;
    GroundY  = 10'(gnd);
    sb.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge frame_clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.tag, "TankS", int'(TankS), 4);
        if (e.m & M_X)  chk(e.tag, "TankX", int'(TankX), e.x);
        if (e.m & M_Y)  chk(e.tag, "TankY", int'(TankY), e.y);
        if (e.m & M_D)  chk(e.tag, "Direction", int'(Direction), e.dir);
        if (e.m & M_A)  chk(e.tag, "Aim", int'(Aim), e.aim);
        if (e.m & M_S)  chk(e.tag, "shoot", int'(shoot), e.sh);
        if (e.m & M_H)  chk(e.tag, "HP", int'(HP), e.hp);
        if (e.m & M_AL) chk(e.tag, "alive", int'(alive), e.al);
        if (e.m & M_IV) chk(e.tag, "invuln", int'(invuln), e.inv);
      end
    end
  end

  initial begin
    Reset = 1'b1; keycodes = '0; hit = 1'b0; GroundY = 10'd100;

    // Reset with FIRE held, then release: held key is a fresh press.
    for (int i = 0; i < 2; i++) frame(kc(K_F, K_N, K_N), 1'b0, 1'b1, mk("reset", M_ALL, 140, 0, 1, 0, 0, 10, 1, 0));
    frame(kc(K_F, K_N, K_N), 1'b0, 1'b0, mk("reset_fire", M_ALL, 140, 96, 1, 0, 1, 10, 1, 0));

    // Walk left to 6, then into the clamp.
    for (int i = 0; i < 134; i++) frame(kc(K_L, K_N, K_N), 1'b0, 1'b0, mk("walk", M_X | M_D, 139 - i, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) frame(kc(K_N, K_L, K_N), 1'b0, 1'b0, mk("clamp_lo", M_X | M_D, (i == 0) ? 5 : 4, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 2; i++) frame(kc(K_L, K_N, K_R), 1'b0, 1'b0, mk("both_lr", M_X | M_D, 4, 0, 0, 0, 0, 0, 0, 0));

    gnd = 2;   frame('0, 1'b0, 1'b0, mk("terrain_sat", M_Y | M_X, 4, 0, 0, 0, 0, 0, 0, 0));
    gnd = 50;  frame('0, 1'b0, 1'b0, mk("terrain_50", M_Y, 0, 46, 0, 0, 0, 0, 0, 0));
    gnd = 100; frame('0, 1'b0, 1'b0, mk("terrain_100", M_Y, 0, 96, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < 3; i++) frame(kc(K_R, K_N, K_N), 1'b0, 1'b0, mk("right", M_X | M_D, 5 + i, 0, 1, 0, 0, 0, 0, 0));
    frame(kc(K_R, K_L, K_N), 1'b0, 1'b0, mk("both_rl", M_X | M_D, 7, 0, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 630; i++) frame(kc(K_N, K_N, K_R), 1'b0, 1'b0, mk("clamp_hi", M_X | M_D, (8 + i > 635) ? 635 : 8 + i, 0, 1, 0, 0, 0, 0, 0));
    frame('0, 1'b0, 1'b0, mk("idle", M_X, 635, 0, 0, 0, 0, 0, 0, 0));

    // Aim: held key steps once, pulses saturate, both edges cancel.
    for (int i = 0; i < 40; i++) frame(kc(K_U, K_N, K_N), 1'b0, 1'b0, mk("aim_hold", M_A, 0, 0, 0, 3, 0, 0, 0, 0));
    frame('0, 1'b0, 1'b0, mk("aim_rel", M_A, 0, 0, 0, 3, 0, 0, 0, 0));
    for (int j = 1; j <= 25; j++) begin
      frame(kc(K_N, K_U, K_N), 1'b0, 1'b0, mk("aim_up", M_A, 0, 0, 0, (3 + 3 * j > 60) ? 60 : 3 + 3 * j, 0, 0, 0, 0));
      frame('0, 1'b0, 1'b0, mk("aim_up_rel", M_A, 0, 0, 0, (3 + 3 * j > 60) ? 60 : 3 + 3 * j, 0, 0, 0, 0));
    end
    frame(kc(K_D, K_N, K_N), 1'b0, 1'b0, mk("aim_dn", M_A, 0, 0, 0, 57, 0, 0, 0, 0));
    frame('0, 1'b0, 1'b0, mk("aim_dn_rel", M_A, 0, 0, 0, 57, 0, 0, 0, 0));
    frame(kc(K_U, K_D, K_N), 1'b0, 1'b0, mk("aim_both", M_A, 0, 0, 0, 57, 0, 0, 0, 0));
    frame('0, 1'b0, 1'b0, mk("aim_both_rel", M_A, 0, 0, 0, 57, 0, 0, 0, 0));
    for (int j = 1; j <= 20; j++) begin
      frame(kc(K_D, K_N, K_N), 1'b0, 1'b0, mk("aim_down", M_A, 0, 0, 0, (57 - 3 * j < 0) ? 0 : 57 - 3 * j, 0, 0, 0, 0));
      frame('0, 1'b0, 1'b0, mk("aim_down_rel", M_A, 0, 0, 0, (57 - 3 * j < 0) ? 0 : 57 - 3 * j, 0, 0, 0, 0));
    end

    // Fire: edges every other frame, shots only when reload is empty; edge at counter=1 dropped.
    for (int k = 0; k <= 92; k++) begin
      frame(((k <= 60) ? (k % 2 == 0) : (k == 89 || k == 90 || k == 92)) ? kc(K_F, K_N, K_N) : 48'h0,
            1'b0, 1'b0,
            mk("fire", M_S, 0, 0, 0, 0, (k == 0 || k == 30 || k == 60 || k == 92) ? 1 : 0, 0, 0, 0));
    end

    // Hit every frame: counted at t, t+20, t+40.
    for (int k = 0; k <= 40; k++) begin
      frame('0, 1'b1, 1'b0, mk("hit_stream", M_H | M_IV | M_AL, 0, 0, 0, 0, 0,
                               (k < 20) ? 9 : ((k < 40) ? 8 : 7), 1, (k == 19 || k == 39) ? 0 : 1));
    end
    for (int j = 0; j < 20; j++) frame('0, 1'b0, 1'b0, mk("invuln_end", (j == 19) ? (M_IV | M_AL) : 0, 0, 0, 0, 0, 0, 0, 1, 0));

    // Walk HP down to 1; first hit carries a shot and a move.
    for (int j = 0; j < 6; j++) begin
      if (j == 0) frame(kc(K_F, K_L, K_N), 1'b1, 1'b0, mk("hit_fire_move", M_X | M_D | M_S | M_H | M_IV, 634, 0, 0, 0, 1, 6, 1, 1));
      else        frame('0, 1'b1, 1'b0, mk("hit_down", M_H | M_IV, 0, 0, 0, 0, 0, 6 - j, 1, 1));
      for (int i = 0; i < 19; i++) frame('0, 1'b0, 1'b0, mk("recover", (i == 18) ? M_IV : 0, 0, 0, 0, 0, 0, 0, 1, 0));
    end

    // Fatal hit with FIRE, frozen while DEAD, respawn after 120 frames.
    frame(kc(K_F, K_N, K_N), 1'b1, 1'b0, mk("fatal", M_S | M_H | M_AL | M_IV, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 119; k++) begin
      frame((k % 2 == 1) ? kc(K_L, K_U, K_F) : 48'h0, 1'b0, 1'b0,
            mk("dead", M_X | M_D | M_A | M_S | M_H | M_AL, 634, 0, 0, 0, 0, 0, 0, 0));
    end
    frame('0, 1'b0, 1'b0, mk("respawn", M_X | M_D | M_A | M_H | M_AL | M_IV, 140, 0, 1, 0, 0, 10, 1, 0));

    // Die again, then Reset while DEAD.
    for (int j = 0; j < 9; j++) begin
      frame('0, 1'b1, 1'b0, mk("hit_again", M_H, 0, 0, 0, 0, 0, 9 - j, 1, 0));
      for (int i = 0; i < 19; i++) frame('0, 1'b0, 1'b0, mk("recover2", 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    frame('0, 1'b1, 1'b0, mk("fatal2", M_H | M_AL, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) frame('0, 1'b0, 1'b0, mk("dead2", M_AL, 0, 0, 0, 0, 0, 0, 0, 0));
    frame('0, 1'b0, 1'b1, mk("reset_dead", M_ALL, 140, 0, 1, 0, 0, 10, 1, 0));
    frame('0, 1'b0, 1'b0, mk("after_reset", M_X | M_Y | M_H | M_AL | M_IV, 140, 96, 0, 0, 0, 10, 1, 0));

    repeat (3) @(posedge frame_clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
